// File: rtl/serdiv_radix.sv
// Iterative restoring integer divider retiring BITS_PER_CYCLE quotient bits per clock,
// with a single-cycle fast path for divide-by-zero, signed overflow and |a| < |b|.
module serdiv_radix #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ID_WIDTH       = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                flush_i,
    input  logic [ID_WIDTH-1:0] id_i,
    input  logic [WIDTH-1:0]    op_a_i,
    input  logic [WIDTH-1:0]    op_b_i,
    input  logic [2:0]          opcode_i,
    input  logic                in_vld_i,
    output logic                in_rdy_o,
    output logic                out_vld_o,
    input  logic                out_rdy_i,
    output logic [ID_WIDTH-1:0] id_o,
    output logic [WIDTH-1:0]    res_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int CNT_W = $clog2(WIDTH / BITS_PER_CYCLE + 1);
    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(WIDTH / BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32 / BITS_PER_CYCLE);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    div_q, div_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                remSel_q, remSel_d;
    logic                negQ_q, negQ_d;
    logic                negR_q, negR_d;
    logic                word_q, word_d;

    logic             isSigned, remSel, word, accept;
    logic [WIDTH-1:0] aExt, bExt, absA, absB, minVal, fastRes, wordA;
    logic             aNeg, bNeg, bZero, overflow, smaller, fast;
    logic [WIDTH-1:0] stepRem, stepQuo, qFix, rFix, sel, divRes;
    logic [WIDTH:0]   shifted, diff;

    function automatic logic [WIDTH-1:0] wordExt(input logic w, input logic [WIDTH-1:0] x);
        return w ? {{(WIDTH-32){x[31]}}, x[31:0]} : x;
    endfunction

    assign in_rdy_o  = ((state_q == IDLE) | ((state_q == FINISH) & out_rdy_i)) & ~flush_i & rst_ni;
    assign out_vld_o = (state_q == FINISH) & ~flush_i;
    assign res_o     = res_q;
    assign id_o      = id_q;
    assign accept    = in_vld_i & in_rdy_o;

    // Operands are reduced to magnitudes; word mode sign- or zero-extends the low half first.
    always_comb begin
        isSigned = opcode_i[0];
        remSel   = opcode_i[1];
        word     = opcode_i[2];
        aExt     = word ? {{(WIDTH-32){isSigned & op_a_i[31]}}, op_a_i[31:0]} : op_a_i;
        bExt     = word ? {{(WIDTH-32){isSigned & op_b_i[31]}}, op_b_i[31:0]} : op_b_i;
        aNeg     = isSigned & aExt[WIDTH-1];
        bNeg     = isSigned & bExt[WIDTH-1];
        absA     = aNeg ? -aExt : aExt;
        absB     = bNeg ? -bExt : bExt;
        minVal   = word ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};
        bZero    = (bExt == '0);
        overflow = isSigned & (aExt == minVal) & (bExt == '1);
        smaller  = (absA < absB);
        fast     = bZero | overflow | smaller;
        wordA    = wordExt(word, op_a_i);
        if (bZero)
            fastRes = remSel ? wordA : '1;
        else if (overflow)
            fastRes = remSel ? '0 : aExt;
        else
            fastRes = remSel ? wordA : '0;
    end

    // Chained restoring steps; the WIDTH+1 bit trial result's MSB is the borrow.
    always_comb begin
        stepRem = rem_q;
        stepQuo = quo_q;
        shifted = '0;
        diff    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {stepRem, stepQuo[WIDTH-1]};
            diff    = shifted - {1'b0, div_q};
            stepQuo = {stepQuo[WIDTH-2:0], ~diff[WIDTH]};
            stepRem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
        qFix   = negQ_q ? -stepQuo : stepQuo;
        rFix   = negR_q ? -stepRem : stepRem;
        sel    = remSel_q ? rFix : qFix;
        divRes = wordExt(word_q, sel);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        res_d    = res_q;
        id_d     = id_q;
        remSel_d = remSel_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        word_d   = word_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (accept) begin
            id_d     = id_i;
            remSel_d = remSel;
            negQ_d   = aNeg ^ bNeg;
            negR_d   = aNeg;
            word_d   = word;
            div_d    = absB;
            if (fast) begin
                state_d = FINISH;
                cnt_d   = '0;
                res_d   = fastRes;
            end else begin
                // Word-mode dividends sit in the top half so only 32 steps are needed.
                state_d = DIVIDE;
                cnt_d   = word ? N_WORD : N_FULL;
                rem_d   = '0;
                quo_d   = word ? (absA << (WIDTH - 32)) : absA;
            end
        end else begin
            case (state_q)
                DIVIDE: begin
                    rem_d = stepRem;
                    quo_d = stepQuo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FINISH;
                        res_d   = divRes;
                    end
                end
                FINISH: begin
                    if (out_rdy_i)
                        state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            res_q    <= '0;
            id_q     <= '0;
            remSel_q <= 1'b0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            res_q    <= res_d;
            id_q     <= id_d;
            remSel_q <= remSel_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            word_q   <= word_d;
        end
    end

endmodule

// File: tb/tb_serdiv_radix.sv
// Directed bench for serdiv_radix: three instances (1, 2 and 4 bits per cycle) share
// the same stimulus; results and latencies are compared against hand-computed values.
module tb_serdiv_radix;

    typedef struct {
        logic [2:0]  opcode;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expRes;
        bit          fast;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        clrIn = 1'b0;
    logic        flushIn = 1'b0;
    logic [2:0]  idIn = '0;
    logic [63:0] opA = '0;
    logic [63:0] opB = '0;
    logic [2:0]  opcode = '0;
    logic        inVld = 1'b0;
    logic        outRdy = 1'b1;
    logic        inRdy[3];
    logic        outVld[3];
    logic [2:0]  idOut[3];
    logic [63:0] res[3];

    int   cmpCount = 0;
    int   failCount = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serdiv_radix #(.WIDTH(64), .BITS_PER_CYCLE(1 << g), .ID_WIDTH(3)) dut (
            .clk_i(clk), .rst_ni(rstN), .clr_i(clrIn), .flush_i(flushIn),
            .id_i(idIn), .op_a_i(opA), .op_b_i(opB), .opcode_i(opcode),
            .in_vld_i(inVld), .in_rdy_o(inRdy[g]), .out_vld_o(outVld[g]),
            .out_rdy_i(outRdy), .id_o(idOut[g]), .res_o(res[g])
        );
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        cmpCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one request to all instances and collect the first result of each.
    task automatic applyStimulus(input logic [2:0] id, input logic [2:0] opc, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] exp, input bit fast,
                                 input string name);
        int          lat[3];
        logic [63:0] got[3];
        logic [2:0]  gotId[3];
        bit          seen[3];
        int          expLat;
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0;
            lat[k]  = 0;
        end
        @(negedge clk);
        idIn = id; opA = a; opB = b; opcode = opc; inVld = 1'b1;
        @(posedge clk);
        #1 inVld = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (outVld[k] && !seen[k]) begin
                    seen[k]  = 1'b1;
                    lat[k]   = c;
                    got[k]   = res[k];
                    gotId[k] = idOut[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            expLat = fast ? 1 : ((opc[2] ? 32 : 64) >> k) + 1;
            if (!seen[k]) begin
                cmpCount++;
                failCount++;
                $display("[TB] FAIL %s/bpc%0d timeout: got no out_vld, expected one", name, 1 << k);
            end else begin
                checkOutput($sformatf("%s/bpc%0d res", name, 1 << k), got[k], exp);
                checkOutput($sformatf("%s/bpc%0d latency", name, 1 << k), 64'(lat[k]), 64'(expLat));
                checkOutput($sformatf("%s/bpc%0d id", name, 1 << k), 64'(gotId[k]), 64'(id));
            end
        end
    endtask

    task automatic watchNoResult(input string name);
        logic sawVld = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (outVld[k]) sawVld = 1'b1;
        end
        checkOutput(name, 64'(sawVld), 64'd0);
    endtask

    initial begin
        bit found;
        int lat;

        vecs[0]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div -7/2"};
        vecs[1]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "rem -7%2"};
        vecs[2]  = '{3'b000, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "udiv 7/0"};
        vecs[3]  = '{3'b010, 64'd7, 64'd0, 64'd7, 1'b1, "urem 7%0"};
        vecs[4]  = '{3'b101, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, "divw ovf"};
        vecs[5]  = '{3'b111, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "remw ovf"};
        vecs[6]  = '{3'b100, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "divuw sext"};
        vecs[7]  = '{3'b000, 64'd100, 64'd7, 64'd14, 1'b0, "udiv 100/7"};
        vecs[8]  = '{3'b010, 64'd100, 64'd7, 64'd2, 1'b0, "urem 100%7"};
        vecs[9]  = '{3'b000, 64'd3, 64'd10, 64'd0, 1'b1, "udiv 3/10"};
        vecs[10] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 1'b0, "udiv max/3"};
        vecs[11] = '{3'b111, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "remw -7%2"};
        vecs[12] = '{3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, "div ovf"};
        vecs[13] = '{3'b101, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, "divw 100/-7"};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_vld", 64'(outVld[0]), 64'd0);
        checkOutput("reset res", res[0], 64'd0);
        checkOutput("reset id", 64'(idOut[0]), 64'd0);
        checkOutput("reset in_rdy", 64'(inRdy[0]), 64'd0);
        rstN = 1'b1;
        #1 checkOutput("release in_rdy", 64'(inRdy[0]), 64'd1);

        for (int i = 0; i < 14; i++)
            applyStimulus(3'(i + 1), vecs[i].opcode, vecs[i].a, vecs[i].b, vecs[i].expRes,
                          vecs[i].fast, vecs[i].name);

        // Back-to-back with back-pressure
        outRdy = 1'b0;
        @(negedge clk);
        idIn = 3'd1; opA = 64'd100; opB = 64'd7; opcode = 3'b000; inVld = 1'b1;
        @(posedge clk);
        #1 inVld = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (outVld[0]) begin
                found = 1'b1;
                lat = c;
                break;
            end
        end
        checkOutput("b2b first result seen", 64'(found), 64'd1);
        checkOutput("b2b first latency", 64'(lat), 64'd65);
        repeat (5) begin
            checkOutput("stall out_vld", 64'(outVld[0]), 64'd1);
            checkOutput("stall res", res[0], 64'd14);
            checkOutput("stall id", 64'(idOut[0]), 64'd1);
            @(negedge clk);
        end
        outRdy = 1'b1;
        idIn = 3'd2; opA = 64'd3; opB = 64'd10; inVld = 1'b1;
        #1 checkOutput("b2b in_rdy", 64'(inRdy[0]), 64'd1);
        @(posedge clk);
        #1 inVld = 1'b0;
        @(negedge clk);
        checkOutput("b2b second out_vld", 64'(outVld[0]), 64'd1);
        checkOutput("b2b second res", res[0], 64'd0);
        checkOutput("b2b second id", 64'(idOut[0]), 64'd2);
        @(negedge clk);
        checkOutput("b2b drained", 64'(outVld[0]), 64'd0);

        // Flush at DIVIDE cycle 10
        idIn = 3'd5; opA = 64'd1000; opB = 64'd3; opcode = 3'b000; inVld = 1'b1;
        @(posedge clk);
        #1 inVld = 1'b0;
        repeat (10) @(negedge clk);
        flushIn = 1'b1;
        idIn = 3'd4; inVld = 1'b1;
        #1 checkOutput("flush in_rdy", 64'(inRdy[0]), 64'd0);
        @(posedge clk);
        #1 flushIn = 1'b0;
        inVld = 1'b0;
        @(negedge clk);
        checkOutput("post-flush in_rdy", 64'(inRdy[0]), 64'd1);
        watchNoResult("flush no result");
        applyStimulus(3'd6, 3'b000, 64'd9, 64'd3, 64'd3, 1'b0, "udiv 9/3");

        // Reset mid-divide
        @(negedge clk);
        idIn = 3'd7; opA = 64'd1000; opB = 64'd3; opcode = 3'b000; inVld = 1'b1;
        @(posedge clk);
        #1 inVld = 1'b0;
        repeat (10) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midreset out_vld", 64'(outVld[0]), 64'd0);
        checkOutput("midreset res", res[0], 64'd0);
        checkOutput("midreset id", 64'(idOut[0]), 64'd0);
        checkOutput("midreset in_rdy", 64'(inRdy[0]), 64'd0);
        rstN = 1'b1;
        #1 checkOutput("midreset release in_rdy", 64'(inRdy[0]), 64'd1);
        watchNoResult("reset no result");
        applyStimulus(3'd3, 3'b010, 64'd9, 64'd4, 64'd1, 1'b0, "urem 9%4");

        $display("== %0d vectors applied, %0d miscompares ==", cmpCount, failCount);
        $finish;
    end

endmodule
